// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM states, frame config bundle
// and data-length encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam logic UART_IDLE_LVL = 1'b1;

    typedef struct packed {
        logic [1:0] data_bits;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } tx_cfg_t;

    // Index of the final data bit for a given data-length code.
    function automatic logic [2:0] last_bit_idx(logic [1:0] db);
        logic [2:0] idx;
        idx = 3'd7;
        unique case (1'b1)
            db == DBITS_5: idx = 3'd4;
            db == DBITS_6: idx = 3'd5;
            db == DBITS_7: idx = 3'd6;
            db == DBITS_8: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Transmit FIFO read port: registered data, empty flag and
// one-cycle read strobe.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd;

    modport master (
        output fifo_rd,
        input  fifo_data,
        input  fifo_empty
    );

    modport slave (
        input  fifo_rd,
        output fifo_data,
        output fifo_empty
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..div and emits one-cycle tick
// on the final count. Shared by transmit and receive paths.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q + DIV_W'(1);
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q >= div) begin
            tick  = (cnt_q == div);
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from the TX FIFO and
// shifts the low byte out as an async serial frame.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_serializer_if.master fifo,
    input  logic                tx_en,
    input  logic [DIV_W-1:0]    baud_div,
    input  logic [1:0]          data_bits,
    input  logic                par_en,
    input  logic                par_odd,
    input  logic                stop2,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);

    tx_state_t        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic             par_q, par_d;
    tx_cfg_t          cfg_q, cfg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             busy_q, fifo_rd_q, done_q;
    logic             clear, tick;

    logic unused_fifo_hi;
    assign unused_fifo_hi = ^fifo.fifo_data[DATA_W-1:8];

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        cfg_d   = cfg_q;
        div_d   = div_q;
        tx_d    = tx_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (tx_en && !fifo.fifo_empty) state_d = POP;
            end
            POP: state_d = LOAD;
            LOAD: begin
                shift_d = fifo.fifo_data[7:0];
                cfg_d   = '{data_bits, par_en, par_odd, stop2};
                div_d   = baud_div;
                bit_d   = '0;
                par_d   = 1'b0;
                clear   = 1'b1;
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (tick) begin
                // Parity folds in only the bits actually sent.
                par_d   = par_q ^ shift_q[0];
                shift_d = shift_q >> 1;
                if (bit_q == last_bit_idx(cfg_q.data_bits)) begin
                    bit_d = '0;
                    if (cfg_q.par_en) begin
                        state_d = PARITY;
                        tx_d    = par_d ^ cfg_q.par_odd;
                    end else begin
                        state_d = STOP;
                        tx_d    = UART_IDLE_LVL;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = shift_q[1];
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = UART_IDLE_LVL;
            end
            STOP: if (tick) begin
                if (cfg_q.stop2 && bit_q == 3'd0) begin
                    bit_d = 3'd1;
                end else begin
                    bit_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            cfg_q     <= '0;
            div_q     <= '0;
            tx_q      <= UART_IDLE_LVL;
            busy_q    <= 1'b0;
            fifo_rd_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            cfg_q     <= cfg_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != IDLE);
            fifo_rd_q <= (state_d == POP);
            done_q    <= (state_q == STOP) && (state_d == IDLE);
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign fifo.fifo_rd = fifo_rd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: hand-computed frames
// checked bit by bit against a simple FIFO model.
module tb_uart_tx_serializer;

    localparam int DIV_W  = 16;
    localparam int DATA_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx_en = 1'b0;
    logic [DIV_W-1:0] baud_div = '0;
    logic [1:0]       data_bits = 2'd0;
    logic             par_en = 1'b0;
    logic             par_odd = 1'b0;
    logic             stop2 = 1'b0;
    logic             tx, busy, frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int n_rd = 0;
    int rd_ptr = 0;
    int wr_ptr = 0;
    logic [31:0] words [0:15];

    uart_tx_serializer_if #(.DATA_W(DATA_W)) fif();

    assign fif.fifo_empty = (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fif.fifo_rd) begin
            fif.fifo_data <= words[rd_ptr[3:0]];
            rd_ptr        <= rd_ptr + 1;
            n_rd          <= n_rd + 1;
        end
    end

    uart_tx_serializer #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .fifo       (fif),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .data_bits  (data_bits),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .stop2      (stop2),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(logic [1:0] db, logic pe, logic po,
                           logic s2, int div);
        data_bits = db;
        par_en    = pe;
        par_odd   = po;
        stop2     = s2;
        baud_div  = DIV_W'(div);
    endtask

    task automatic push(logic [31:0] w);
        words[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_bits(string tag, logic [15:0] bits,
                              int lo, int hi, int per);
        for (int i = lo; i <= hi; i++) begin
            int m;
            m = 0;
            for (int c = 0; c < per; c++) begin
                if (tx === bits[i]) m++;
                @(negedge clk);
            end
            chk($sformatf("%s[%0d]", tag, i), m, per);
        end
    endtask

    initial begin
        int m, lat, gap, r0;

        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fif.fifo_rd, 0);
        chk("rst_done", frame_done, 0);
        rst_n = 1'b1;

        m = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b1 && busy === 1'b0 && fif.fifo_rd === 1'b0) m++;
        end
        chk("idle100", m, 100);

        // 8N1, 4-cycle bits
        set_cfg(2'd3, 0, 0, 0, 3);
        r0 = n_rd;
        push(32'h0000_00A5);
        wait_fall(lat);
        chk("8n1_lat", lat, 3);
        chk("8n1_busy", busy, 1);
        check_bits("8n1", {6'h0, 1'b1, 8'hA5, 1'b0}, 0, 9, 4);
        chk("8n1_done", frame_done, 1);
        chk("8n1_busy_end", busy, 0);
        @(negedge clk);
        chk("8n1_done_pulse", frame_done, 0);
        chk("8n1_rd", n_rd - r0, 1);

        // 7E2, 1-cycle bits, upper word bits set
        set_cfg(2'd2, 1, 0, 1, 0);
        push(32'hFFFF_FF03);
        wait_fall(lat);
        chk("7e2_lat", lat, 3);
        check_bits("7e2", {5'h0, 1'b1, 1'b1, 1'b0, 7'h03, 1'b0}, 0, 10, 1);
        chk("7e2_done", frame_done, 1);

        // 8O1, two back-to-back words
        set_cfg(2'd3, 1, 1, 0, 1);
        r0 = n_rd;
        push(32'h0000_0000);
        push(32'h0000_00FF);
        wait_fall(lat);
        chk("8o1_lat", lat, 3);
        check_bits("8o1a", {5'h0, 1'b1, 1'b1, 8'h00, 1'b0}, 0, 10, 2);
        chk("8o1a_done", frame_done, 1);
        wait_fall(gap);
        chk("8o1_gap", gap, 3);
        check_bits("8o1b", {5'h0, 1'b1, 1'b1, 8'hFF, 1'b0}, 0, 10, 2);
        chk("8o1b_done", frame_done, 1);
        chk("8o1_rd", n_rd - r0, 2);

        // CSR change and tx_en drop mid-frame
        set_cfg(2'd3, 0, 0, 0, 2);
        r0 = n_rd;
        push(32'h0000_003C);
        push(32'h0000_0011);
        wait_fall(lat);
        chk("mid_lat", lat, 3);
        check_bits("mid", {6'h0, 1'b1, 8'h3C, 1'b0}, 0, 2, 3);
        baud_div = DIV_W'(9);
        tx_en    = 1'b0;
        check_bits("mid", {6'h0, 1'b1, 8'h3C, 1'b0}, 3, 9, 3);
        chk("mid_done", frame_done, 1);
        m = 0;
        repeat (50) begin
            if (tx === 1'b1 && busy === 1'b0 && fif.fifo_rd === 1'b0) m++;
            @(negedge clk);
        end
        chk("off_idle", m, 50);
        chk("off_rd", n_rd - r0, 1);

        // Reset during DATA; popped word is dropped
        set_cfg(2'd3, 0, 0, 0, 3);
        r0 = n_rd;
        tx_en = 1'b1;
        wait_fall(lat);
        chk("pre_lat", lat, 3);
        repeat (9) @(negedge clk);
        chk("pre_rst_tx", tx, 0);
        chk("pre_rst_busy", busy, 1);
        push(32'h0000_005A);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_fall(lat);
        chk("post_lat", lat, 3);
        check_bits("post", {6'h0, 1'b1, 8'h5A, 1'b0}, 0, 9, 4);
        chk("post_done", frame_done, 1);
        chk("post_rd", n_rd - r0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer for the UART: drains 32-bit words from the transmit FIFO and shifts out the low byte of each word as an asynchronous serial frame on `tx`. Sits directly downstream of the transmit FIFO, driving its read strobe and consuming its registered data output. Frame format (data bits, parity, stop bits) and baud divisor come from CSR fields and are sampled once per frame.

## Interface
Parameters:
- `DIV_W`, 16: width of the baud divisor.
- `DATA_W`, 32: FIFO word width. Only bits [7:0] are transmitted.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `fifo_data`  in  DATA_W: FIFO read data. Valid on the cycle after `fifo_rd` is asserted.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd`  out  1: one-cycle read strobe to the FIFO (its `Out_en`).
- `tx_en`  in  1: transmitter enable from CSR.
- `baud_div`  in  DIV_W: bit period minus one, in clk cycles.
- `data_bits`  in  2: data bits per frame, 0=5, 1=6, 2=7, 3=8.
- `par_en`  in  1: parity enable.
- `par_odd`  in  1: 1=odd parity, 0=even parity.
- `stop2`  in  1: 1=two stop bits, 0=one stop bit.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high in every state except IDLE.
- `frame_done`  out  1: one-cycle pulse at the end of the last stop bit.

## Operation
- States:
  - IDLE → POP when `tx_en && !fifo_empty`.
  - POP → LOAD, always.
  - LOAD → START, always.
  - START → DATA after one bit period.
  - DATA → PARITY, or → STOP if parity is disabled, after N bits.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after 1 or 2 bit periods.
- POP: `fifo_rd`=1 for exactly this cycle.
- LOAD:
  - Capture `fifo_data[7:0]` into the shift register.
  - Latch `data_bits`, `par_en`, `par_odd`, `stop2` and `baud_div`.
  - Clear the bit counter and the baud counter.
  - CSR changes mid-frame have no effect until the next LOAD.
- Bit order is LSB first. START drives 0. STOP drives 1.
- Parity is the XOR of the N transmitted bits only, not the unused upper bits. Odd parity inverts that XOR.
- Data bits above N are ignored.
- `tx_en` deasserted mid-frame: the frame completes, then the block stays in IDLE.
- `fifo_empty` is sampled only in IDLE. Popping an empty FIFO never occurs.
- A reset mid-frame aborts immediately: `tx`=1 and the state returns to IDLE. The word already popped is lost.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0.
- Bit period = `baud_div`+1 clk cycles. `baud_div`=0 gives a 1-cycle bit.
- Baud counter arithmetic:
  - The counter is DIV_W bits wide and counts 0..latched `baud_div`.
  - A tick fires when the count equals the divisor, then the counter wraps to 0.
  - The counter never overflows past the divisor.
- `tx` is registered. In START, `tx` falls on the first cycle and holds for exactly one bit period.
- Latency from `fifo_empty` falling (IDLE, `tx_en`=1) to `tx` falling: 3 cycles (POP, LOAD, START edge).
- Frame length in clk cycles = (1 + N + `par_en` + 1 + `stop2`) × (`baud_div`+1).
- `frame_done` is asserted on the same cycle the FSM re-enters IDLE.
- Back-to-back frames: with the FIFO non-empty, IDLE lasts 1 cycle. The gap between the last stop bit and the next start bit is exactly 3 cycles of idle-high.
- `busy` is registered from the state. It is 1 from POP through the last STOP cycle.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
  - Data-bit encoding constants.
  - `UART_IDLE_LVL`=1'b1.
- Sub-module `uart_baud_gen`:
  - Inputs: clk, reset, clear, div.
  - Output: one-cycle `tick`.
  - Shared later with the receive path.
- The FSM, shift register, bit counter and parity accumulator stay in `uart_tx_serializer`.

## Test plan
- Reset, FIFO empty, `tx_en`=1:
  - `tx`=1, `busy`=0 and `fifo_rd`=0 for 100 cycles.
- 8N1, `baud_div`=3, FIFO word 0x000000A5:
  - One `fifo_rd` pulse.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `frame_done` pulses after 40 cycles.
- 7E2, `baud_div`=0, word 0xFFFFFF03:
  - Data bits 1,1,0,0,0,0,0, then parity 0, then stop bits 1,1.
  - Upper bits are ignored.
- 8O1, `baud_div`=1, two queued words 0x00, then 0xFF:
  - First frame parity bit is 1, second frame parity bit is 1.
  - Exactly 3 idle-high cycles between the frames.
  - Exactly two `fifo_rd` pulses.
- `baud_div` changed to 9 and `tx_en` dropped mid-frame (set to 2):
  - The current frame keeps a 3-cycle bit period and completes.
  - No further `fifo_rd` pulses while `tx_en`=0.
- Reset asserted during DATA:
  - `tx`=1 and `busy`=0 on the same cycle.
  - After release, the next frame starts cleanly from the next FIFO word.
